// File: rtl/encoder_ctrl_pkg.sv
// Shared definitions for the arithmetic-encoder control blocks (symbol issue and stage-enable units).
package encoder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  localparam int PIPE_STAGES_DEF = 3;

  // Counter width able to hold ISSUE_GAP-2, never narrower than one bit.
  function automatic int gap_cnt_width(input int gap);
    return (gap > 2) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Show-ahead synchronous FIFO buffering {last, symbol} words ahead of the issue FSM.
module issue_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/symbol_issue_ctrl.sv
// Paces symbols into the 3-stage encoder pipeline and tracks tokens until drain completes.
// Optional macro ISSUE_PERF_CNT_EN adds issued_count/starve_count performance counters.
module symbol_issue_ctrl
  import encoder_ctrl_pkg::*;
#(
  parameter int SYMBOL_W    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ISSUE_GAP   = 2,
  parameter int PIPE_STAGES = PIPE_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SYMBOL_W-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                issue_valid,
  output logic [SYMBOL_W-1:0] issue_data,
  output logic                issue_first,
  output logic                issue_last,
  output logic                out_valid,
  output logic                out_last,
  output logic                flush_done,
  output logic                busy
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]         issued_count,
  output logic [31:0]         starve_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = gap_cnt_width(ISSUE_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'((ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0);

  ctrl_state_t            state;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [SYMBOL_W:0]      head_data;
  logic                   pop;
  logic                   post_gap;
  logic [GW-1:0]          gap_cnt;
  logic                   first_flag;
  logic                   last_pending;
  logic [PIPE_STAGES-1:0] trk_valid;
  logic [PIPE_STAGES-1:0] trk_last;
  logic [PIPE_STAGES-1:0] nxt_valid;
  logic [PIPE_STAGES-1:0] nxt_last;

  issue_fifo #(
    .WIDTH (SYMBOL_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_last, in_data}),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = trk_valid[PIPE_STAGES-1];
  assign out_last  = trk_last[PIPE_STAGES-1];
  assign busy      = (state != IDLE) || (fifo_count != '0) || (trk_valid != '0);

  // A symbol following a last one stays queued until the drain finishes.
  always_comb begin
    post_gap  = ((state == GAP) && (gap_cnt == '0)) || ((state == ISSUE) && (ISSUE_GAP == 1));
    pop       = !fifo_empty && ((state == IDLE) || (post_gap && !last_pending));
    nxt_valid = PIPE_STAGES'({trk_valid, issue_valid});
    nxt_last  = PIPE_STAGES'({trk_last, issue_valid && issue_last});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_valid <= '0;
      trk_last  <= '0;
    end else begin
      trk_valid <= nxt_valid;
      trk_last  <= nxt_last;
    end
  end

  // Drain completes when the tracker is about to become empty, so flush_done
  // lands in the cycle right after the last token leaves the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      issue_valid  <= 1'b0;
      issue_data   <= '0;
      issue_first  <= 1'b0;
      issue_last   <= 1'b0;
      flush_done   <= 1'b0;
      first_flag   <= 1'b1;
      last_pending <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      issue_valid <= 1'b0;
      issue_first <= 1'b0;
      issue_last  <= 1'b0;
      flush_done  <= 1'b0;
      if (pop) begin
        state        <= ISSUE;
        issue_valid  <= 1'b1;
        issue_data   <= head_data[SYMBOL_W-1:0];
        issue_last   <= head_data[SYMBOL_W];
        issue_first  <= first_flag;
        first_flag   <= 1'b0;
        last_pending <= head_data[SYMBOL_W];
      end else begin
        case (state)
          IDLE: state <= IDLE;
          ISSUE: begin
            if (ISSUE_GAP > 1) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= last_pending ? DRAIN : IDLE;
            end
          end
          GAP: begin
            if (gap_cnt == '0) state <= last_pending ? DRAIN : IDLE;
            else gap_cnt <= gap_cnt - 1'b1;
          end
          DRAIN: begin
            if (nxt_valid == '0) begin
              flush_done   <= 1'b1;
              first_flag   <= 1'b1;
              last_pending <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_count <= '0;
      starve_count <= '0;
    end else begin
      if (issue_valid && (issued_count != '1)) issued_count <= issued_count + 1'b1;
      if ((state == IDLE) && !busy && (starve_count != '1)) starve_count <= starve_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_symbol_issue_ctrl.sv
// Directed self-checking bench for symbol_issue_ctrl; perf counters checked when ISSUE_PERF_CNT_EN is defined.
module tb_symbol_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        issue_valid;
  logic [15:0] issue_data;
  logic        issue_first;
  logic        issue_last;
  logic        out_valid;
  logic        out_last;
  logic        flush_done;
  logic        busy;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issued_count;
  logic [31:0] starve_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          iss_cyc[$];
  logic [15:0] iss_data[$];
  bit          iss_first[$];
  bit          iss_last[$];
  int          ov_cyc[$];
  bit          ov_last[$];
  int          fd_cyc[$];

  symbol_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .issue_first (issue_first),
    .issue_last  (issue_last),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .flush_done  (flush_done),
    .busy        (busy)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .issued_count(issued_count),
    .starve_count(starve_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, tagged with the cycle number.
  always @(negedge clk) begin
    if (!reset) begin
      if (issue_valid) begin
        iss_cyc.push_back(cyc);
        iss_data.push_back(issue_data);
        iss_first.push_back(issue_first);
        iss_last.push_back(issue_last);
      end
      if (out_valid) begin
        ov_cyc.push_back(cyc);
        ov_last.push_back(out_last);
      end
      if (flush_done) fd_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    iss_cyc.delete(); iss_data.delete(); iss_first.delete(); iss_last.delete();
    ov_cyc.delete(); ov_last.delete(); fd_cyc.delete();
  endtask

  task automatic push_one(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idle_cycles(2);
    checks++;
    if ({in_ready, issue_valid, issue_first, issue_last, out_valid, out_last, flush_done, busy} !== 8'b1000_0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 10000000",
               {in_ready, issue_valid, issue_first, issue_last, out_valid, out_last, flush_done, busy});
    end
    checks++;
    if (issue_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0000", issue_data);
    end
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_stream();
    int c0;
    logic [15:0] exp_d[3];
    exp_d = '{16'h0011, 16'h0022, 16'h0033};
    clear_log();
    c0 = cyc;
    push_one(16'h0011, 1'b0);
    push_one(16'h0022, 1'b0);
    push_one(16'h0033, 1'b1);
    idle_cycles(12);
    checks++;
    if (iss_cyc.size() != 3) begin
      errors++; $display("[TB] FAIL stream_issue_count: got %0d expected 3", iss_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= iss_cyc.size() || iss_cyc[i] !== c0 + 2 + 2 * i ||
          {iss_data[i], iss_first[i], iss_last[i]} !== {exp_d[i], i == 0, i == 2}) begin
        errors++;
        $display("[TB] FAIL stream_issue%0d: got cyc %0d data %h f%0b l%0b expected cyc %0d data %h f%0b l%0b",
                 i, (i < iss_cyc.size()) ? iss_cyc[i] - c0 : -1, iss_data[i], iss_first[i], iss_last[i],
                 2 + 2 * i, exp_d[i], i == 0, i == 2);
      end
      checks++;
      if (i >= ov_cyc.size() || ov_cyc[i] !== c0 + 5 + 2 * i || ov_last[i] !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL stream_out%0d: got cyc %0d last %0b expected cyc %0d last %0b",
                 i, (i < ov_cyc.size()) ? ov_cyc[i] - c0 : -1, ov_last[i], 5 + 2 * i, i == 2);
      end
    end
    checks++;
    if (fd_cyc.size() != 1 || fd_cyc[0] !== c0 + 10) begin
      errors++;
      $display("[TB] FAIL stream_flush: got %0d pulses first at %0d expected 1 pulse at 10",
               fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] - c0 : -1);
    end
    checks++;
    if (busy !== 1'b0 || ov_cyc.size() != 3) begin
      errors++; $display("[TB] FAIL stream_idle: got busy %b outs %0d expected busy 0 outs 3", busy, ov_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0, j, accepted;
    logic rdy;
    bit exp_rdy[10];
    exp_rdy = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
    clear_log();
    c0 = cyc; j = 0; accepted = 0;
    while (accepted < 8 && j < 40) begin
      rdy = in_ready;
      if (j < 10) begin
        checks++;
        if (rdy !== exp_rdy[j]) begin
          errors++; $display("[TB] FAIL b2b_ready_c%0d: got %b expected %b", j, rdy, exp_rdy[j]);
        end
      end
      in_valid = 1'b1;
      in_data  = 16'(16'h0100 + accepted);
      in_last  = (accepted == 7);
      @(negedge clk);
      if (rdy) accepted++;
      j++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    idle_cycles(25);
    checks++;
    if (accepted != 8 || iss_cyc.size() != 8) begin
      errors++; $display("[TB] FAIL b2b_count: got pushed %0d issued %0d expected 8 8", accepted, iss_cyc.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= iss_cyc.size() || iss_cyc[k] !== c0 + 2 + 2 * k || iss_data[k] !== 16'(16'h0100 + k) ||
          iss_first[k] !== (k == 0)) begin
        errors++;
        $display("[TB] FAIL b2b_issue%0d: got cyc %0d data %h first %0b expected cyc %0d data %h first %0b",
                 k, (k < iss_cyc.size()) ? iss_cyc[k] - c0 : -1, iss_data[k], iss_first[k],
                 2 + 2 * k, 16'(16'h0100 + k), k == 0);
      end
    end
    checks++;
    if (fd_cyc.size() != 1 || fd_cyc[0] !== c0 + 20) begin
      errors++;
      $display("[TB] FAIL b2b_flush: got %0d pulses first at %0d expected 1 pulse at 20",
               fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] - c0 : -1);
    end
  endtask

  task automatic test_idle_gap();
    int c0;
    clear_log();
    c0 = cyc;
    push_one(16'h00AA, 1'b0);
    idle_cycles(4);
    checks++;
    if ({out_valid, busy} !== 2'b11) begin
      errors++; $display("[TB] FAIL idle_gap_out: got ov,busy %b expected 11", {out_valid, busy});
    end
    idle_cycles(1);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++; $display("[TB] FAIL idle_gap_quiet: got ov,busy,rdy %b expected 001", {out_valid, busy, in_ready});
    end
    idle_cycles(4);
    push_one(16'h00BB, 1'b1);
    idle_cycles(8);
    checks++;
    if (iss_cyc.size() != 2 || iss_cyc[0] !== c0 + 2 || iss_first[0] !== 1'b1 ||
        iss_cyc[1] !== c0 + 12 || iss_data[1] !== 16'h00BB || iss_first[1] !== 1'b0 || iss_last[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_gap_issue: got n %0d second %h f%0b l%0b expected n 2 second 00bb f0 l1",
               iss_cyc.size(), iss_data[1], iss_first[1], iss_last[1]);
    end
    checks++;
    if (fd_cyc.size() != 1 || fd_cyc[0] !== c0 + 16) begin
      errors++; $display("[TB] FAIL idle_gap_flush: got %0d pulses expected 1 at 16", fd_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    push_one(16'h0A01, 1'b0);
    push_one(16'h0A02, 1'b0);
    push_one(16'h0A03, 1'b0);
    idle_cycles(2);
    checks++;
    if ({issue_valid, out_valid, busy} !== 3'b011) begin
      errors++; $display("[TB] FAIL midreset_pre: got iv,ov,busy %b expected 011", {issue_valid, out_valid, busy});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, issue_valid, issue_first, issue_last, out_valid, out_last, flush_done, busy} !== 8'b1000_0000) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %b expected 10000000",
               {in_ready, issue_valid, issue_first, issue_last, out_valid, out_last, flush_done, busy});
    end
    idle_cycles(2);
    reset = 1'b0;
    clear_log();
    idle_cycles(12);
    checks++;
    if (iss_cyc.size() != 0 || ov_cyc.size() != 0 || fd_cyc.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got issues %0d outs %0d flushes %0d expected 0 0 0",
               iss_cyc.size(), ov_cyc.size(), fd_cyc.size());
    end
    push_one(16'h0055, 1'b1);
    idle_cycles(8);
    checks++;
    if (iss_cyc.size() != 1 || iss_data[0] !== 16'h0055 || iss_first[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_first: got n %0d data %h first %0b expected n 1 data 0055 first 1",
               iss_cyc.size(), iss_data[0], iss_first[0]);
    end
  endtask

  task automatic test_single();
    int c0;
    clear_log();
    c0 = cyc;
    push_one(16'h1234, 1'b1);
    idle_cycles(8);
    checks++;
    if (iss_cyc.size() != 1 || iss_cyc[0] !== c0 + 2 || iss_data[0] !== 16'h1234 ||
        {iss_first[0], iss_last[0]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL single_issue: got n %0d data %h fl %0b%0b expected n 1 data 1234 fl 11",
               iss_cyc.size(), iss_data[0], iss_first[0], iss_last[0]);
    end
    checks++;
    if (ov_cyc.size() != 1 || ov_cyc[0] !== c0 + 5 || ov_last[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL single_out: got n %0d last %0b expected n 1 at 5 last 1", ov_cyc.size(), ov_last[0]);
    end
    checks++;
    if (fd_cyc.size() != 1 || fd_cyc[0] !== c0 + 6) begin
      errors++;
      $display("[TB] FAIL single_flush: got %0d pulses first at %0d expected 1 pulse at 6",
               fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] - c0 : -1);
    end
  endtask

`ifdef ISSUE_PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b1;
    idle_cycles(1);
    checks++;
    if (issued_count !== 32'd0 || starve_count !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_reset: got %0d %0d expected 0 0", issued_count, starve_count);
    end
    reset = 1'b0;
    idle_cycles(5);
    checks++;
    if (starve_count !== 32'd5) begin
      errors++; $display("[TB] FAIL perf_starve_idle: got %0d expected 5", starve_count);
    end
    push_one(16'h0011, 1'b0);
    push_one(16'h0022, 1'b0);
    push_one(16'h0033, 1'b1);
    idle_cycles(7);
    checks++;
    if (issued_count !== 32'd3 || starve_count !== 32'd6) begin
      errors++; $display("[TB] FAIL perf_stream: got issued %0d starve %0d expected 3 6", issued_count, starve_count);
    end
    idle_cycles(2);
    checks++;
    if (starve_count !== 32'd8) begin
      errors++; $display("[TB] FAIL perf_starve_after: got %0d expected 8", starve_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_idle_gap();
    test_reset_mid();
    test_single();
`ifdef ISSUE_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
